tile_palette_ctrl: RTL and testbench
====================================

Name: tile_palette_ctrl

Overview:
- Owns the 16 tile colours (4x4 grid, RGB332) fed to the VGA drawing program's iRGB0..iRGB15 inputs.
- Takes five board push-buttons: four move a cursor over the grid, one steps the colour of the tile under the cursor.
- Blinks the cursor tile and raises a redraw request/acknowledge handshake toward the CPU core whenever the displayed image changes.

Parameters:
- BLINK_CYCLES, 25000000, clock cycles per blink half-period (>=2).
- COLOR_STEP, 8'd1, increment added to the selected tile colour on Select.

Ports:
- Clock  in  1  system clock.
- Reset  in  1  asynchronous, active-high reset.
- iBtnUp  in  1  raw asynchronous button level.
- iBtnDown  in  1  raw asynchronous button level.
- iBtnLeft  in  1  raw asynchronous button level.
- iBtnRight  in  1  raw asynchronous button level.
- iBtnSelect  in  1  raw asynchronous button level.
- iHighlightEn  in  1  1 = blink cursor tile.
- iRedrawAck  in  1  CPU acknowledges redraw request.
- oRGBBus  out  128  tile k colour at [8k+7:8k]; k = row*4+col, row 0 = top.
- oCursor  out  4  current tile index {row[1:0],col[1:0]}.
- oRedrawReq  out  1  redraw request, level.

Behaviour:
- Reset (async, Reset=1):
  - palette tile k = k*17 (8'h00, 8'h11, ..., 8'hFF).
  - cursor = 0; blink counter = 0; phase = 0; dirty = 0.
  - state = IDLE; oRedrawReq = 0; sync/edge flops = 0.
  - oRGBBus = reset palette; oCursor = 0.
- Button path:
  - per button: 2-FF synchroniser, then rising-edge detect giving a 1-cycle pulse.
  - Raw rise sampled at edge N produces the action at edge N+2.
  - All outputs are registered, so the outputs change at edge N+3.
  - Holding a button produces one action only.
- Action priority when several pulses coincide: Select > Up > Down > Left > Right. One action per cycle; lower-priority pulses in that cycle are discarded.
- Actions:
  - Right: col = col+1 mod 4.
  - Left: col = col-1 mod 4.
  - Down: row = row+1 mod 4.
  - Up: row = row-1 mod 4.
  - Select: tile[cursor] = tile[cursor] + COLOR_STEP, 8-bit wrap (8'hFF+1 = 8'h00).
- Any cursor move also clears the blink counter and phase to 0.
- Blink:
  - counter runs 0..BLINK_CYCLES-1; on wrap, phase toggles.
  - Displayed colour of the cursor tile = stored ^ 8'hFF when phase=1 and iHighlightEn=1; all other tiles show stored values.
  - Deasserting iHighlightEn shows stored values from the next output update; the counter keeps running.
- dirty is set by any action, by a phase toggle while iHighlightEn=1, and by any change of iHighlightEn.
- Handshake FSM, 2 states:
  - IDLE: oRedrawReq=0. If dirty, go to REQ next edge and clear dirty.
  - REQ: oRedrawReq=1, held until iRedrawAck=1 is sampled; then go to IDLE (req low next cycle).
  - Events arriving while in REQ set dirty, so a new request follows after one IDLE cycle.
  - iRedrawAck while in IDLE is ignored.
  - dirty set and ack in the same cycle: dirty stays set.
- Reset mid-handshake: oRedrawReq drops immediately (async); the pending request is lost.

Decomposition:
- Definitions.v gains:
  - `TPC_IDLE / `TPC_REQ state codes.
  - tile-count and grid-size constants (16, 4).
  - `TPC_BTN_* index defines for the packed button vector.
- One sub-module, button_sync_edge: 2-FF synchroniser plus rising-edge pulse. Instantiated 5x.
- Palette is a reg [7:0] array inside the top, flattened to oRGBBus.

Test Plan:
1. Reset, then release: oRGBBus[7:0]=8'h00, oRGBBus[127:120]=8'hFF, oCursor=0, oRedrawReq=0 with no ack.
2. BLINK_CYCLES=4, iHighlightEn=0; pulse iBtnRight twice, iBtnDown once, then iBtnSelect: oCursor=4'b0110, tile 6 = 8'h67, action visible exactly 3 edges after each raw rise.
3. Cursor at 0, iBtnLeft then iBtnUp: oCursor=4'b1111. Set tile 15 (8'hFF) with Select: reads 8'h00.
4. Assert iBtnSelect and iBtnRight in the same cycle: only tile 0 increments, cursor unchanged.
5. Event with ack held low: oRedrawReq rises and stays high 20 cycles. A second event meanwhile, then ack for 1 cycle: req low for one cycle, then high again.
6. BLINK_CYCLES=4, iHighlightEn=1, cursor 0: tile 0 output alternates 8'h00/8'hFF every 4 cycles. Reset asserted mid-REQ drops oRedrawReq without a clock edge.

Source files
------------

// File: rtl/tile_palette_ctrl_pkg.sv
// Shared constants for the tile palette controller: handshake state codes,
// grid geometry and the bit positions of the packed button vector.
package tile_palette_ctrl_pkg;

    localparam int unsigned TPC_TILES = 16;
    localparam int unsigned TPC_GRID  = 4;

    localparam logic [0:0] TPC_IDLE = 1'b0;
    localparam logic [0:0] TPC_REQ  = 1'b1;

    localparam int unsigned TPC_BTN_UP     = 0;
    localparam int unsigned TPC_BTN_DOWN   = 1;
    localparam int unsigned TPC_BTN_LEFT   = 2;
    localparam int unsigned TPC_BTN_RIGHT  = 3;
    localparam int unsigned TPC_BTN_SELECT = 4;
    localparam int unsigned TPC_BTN_COUNT  = 5;

    // Reset palette is a grey-ish ramp 8'h00, 8'h11, ..., 8'hFF.
    function automatic logic [7:0] tpc_reset_color(input int unsigned k);
        return 8'(k * 17);
    endfunction

endpackage

// File: rtl/button_sync_edge.sv
// Two-flop synchroniser for a raw push-button level followed by a
// rising-edge detector producing a single-cycle pulse.
module button_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic pulse
);

    logic sync_a;
    logic sync_b;
    logic prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            prev   <= 1'b0;
        end else begin
            sync_a <= btn;
            sync_b <= sync_a;
            prev   <= sync_b;
        end
    end

    assign pulse = sync_b & ~prev;

endmodule

// File: rtl/tile_palette_ctrl.sv
// 4x4 RGB332 tile palette with button-driven cursor, blinking cursor tile
// and a level redraw request/acknowledge handshake toward the CPU.
module tile_palette_ctrl
    import tile_palette_ctrl_pkg::*;
#(
    parameter int unsigned BLINK_CYCLES = 25000000,
    parameter logic [7:0]  COLOR_STEP   = 8'd1
) (
    input  logic         Clock,
    input  logic         Reset,
    input  logic         iBtnUp,
    input  logic         iBtnDown,
    input  logic         iBtnLeft,
    input  logic         iBtnRight,
    input  logic         iBtnSelect,
    input  logic         iHighlightEn,
    input  logic         iRedrawAck,
    output logic [127:0] oRGBBus,
    output logic [3:0]   oCursor,
    output logic         oRedrawReq
);

    localparam int unsigned CNT_W = (BLINK_CYCLES > 2) ? $clog2(BLINK_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_CYCLES - 1);

    logic [TPC_BTN_COUNT-1:0] btn_raw;
    logic [TPC_BTN_COUNT-1:0] btn_pulse;

    logic [7:0]       palette [TPC_TILES];
    logic [3:0]       cursor;
    logic [3:0]       cursor_next;
    logic             do_select;
    logic             do_move;
    logic             any_action;
    logic [CNT_W-1:0] blink_cnt;
    logic             blink_phase;
    logic             phase_toggle;
    logic             hl_q;
    logic             dirty;
    logic             dirty_set;
    logic [0:0]       state;
    logic [127:0]     rgb_next;

    assign btn_raw[TPC_BTN_UP]     = iBtnUp;
    assign btn_raw[TPC_BTN_DOWN]   = iBtnDown;
    assign btn_raw[TPC_BTN_LEFT]   = iBtnLeft;
    assign btn_raw[TPC_BTN_RIGHT]  = iBtnRight;
    assign btn_raw[TPC_BTN_SELECT] = iBtnSelect;

    for (genvar b = 0; b < TPC_BTN_COUNT; b++) begin : g_btn
        button_sync_edge u_sync (
            .clk   (Clock),
            .rst   (Reset),
            .btn   (btn_raw[b]),
            .pulse (btn_pulse[b])
        );
    end

    // One action per cycle: Select > Up > Down > Left > Right.
    always_comb begin
        cursor_next = cursor;
        do_select   = 1'b0;
        do_move     = 1'b0;
        if (btn_pulse[TPC_BTN_SELECT]) begin
            do_select = 1'b1;
        end else if (btn_pulse[TPC_BTN_UP]) begin
            cursor_next[3:2] = cursor[3:2] - 2'd1;
            do_move          = 1'b1;
        end else if (btn_pulse[TPC_BTN_DOWN]) begin
            cursor_next[3:2] = cursor[3:2] + 2'd1;
            do_move          = 1'b1;
        end else if (btn_pulse[TPC_BTN_LEFT]) begin
            cursor_next[1:0] = cursor[1:0] - 2'd1;
            do_move          = 1'b1;
        end else if (btn_pulse[TPC_BTN_RIGHT]) begin
            cursor_next[1:0] = cursor[1:0] + 2'd1;
            do_move          = 1'b1;
        end
    end

    assign any_action   = |btn_pulse;
    assign phase_toggle = (blink_cnt == CNT_MAX) && !do_move;
    assign dirty_set    = any_action | (phase_toggle & iHighlightEn) | (iHighlightEn ^ hl_q);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int unsigned k = 0; k < TPC_TILES; k++) begin
                palette[k] <= tpc_reset_color(k);
            end
            cursor <= '0;
        end else begin
            if (do_select) begin
                palette[cursor] <= palette[cursor] + COLOR_STEP;
            end
            cursor <= cursor_next;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
            hl_q        <= 1'b0;
        end else begin
            hl_q <= iHighlightEn;
            if (do_move) begin
                blink_cnt   <= '0;
                blink_phase <= 1'b0;
            end else if (blink_cnt == CNT_MAX) begin
                blink_cnt   <= '0;
                blink_phase <= ~blink_phase;
            end else begin
                blink_cnt <= blink_cnt + 1'b1;
            end
        end
    end

    // dirty is only consumed on IDLE->REQ; a new event in that cycle re-arms it.
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= TPC_IDLE;
            dirty <= 1'b0;
        end else begin
            case (state)
                TPC_IDLE: if (dirty) state <= TPC_REQ;
                TPC_REQ:  if (iRedrawAck) state <= TPC_IDLE;
                default:  state <= TPC_IDLE;
            endcase
            dirty <= dirty_set | (dirty & (state != TPC_IDLE));
        end
    end

    assign oRedrawReq = (state == TPC_REQ);

    always_comb begin
        rgb_next = '0;
        for (int unsigned k = 0; k < TPC_TILES; k++) begin
            if (iHighlightEn && blink_phase && (cursor == 4'(k))) begin
                rgb_next[8*k +: 8] = palette[k] ^ 8'hFF;
            end else begin
                rgb_next[8*k +: 8] = palette[k];
            end
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            for (int unsigned k = 0; k < TPC_TILES; k++) begin
                oRGBBus[8*k +: 8] <= tpc_reset_color(k);
            end
            oCursor <= '0;
        end else begin
            oRGBBus <= rgb_next;
            oCursor <= cursor;
        end
    end

endmodule

// File: tb/tb_tile_palette_ctrl.sv
// Directed bench for tile_palette_ctrl: a reference palette/cursor model feeds
// an expectation queue that is drained when the DUT outputs update.
module tb_tile_palette_ctrl;

    logic         Clock = 1'b0;
    logic         Reset;
    logic         iBtnUp = 1'b0, iBtnDown = 1'b0, iBtnLeft = 1'b0;
    logic         iBtnRight = 1'b0, iBtnSelect = 1'b0;
    logic         iHighlightEn = 1'b0;
    logic         iRedrawAck = 1'b0;
    logic [127:0] oRGBBus;
    logic [3:0]   oCursor;
    logic         oRedrawReq;

    always #5 Clock = ~Clock;

    tile_palette_ctrl #(.BLINK_CYCLES(4), .COLOR_STEP(8'd1)) dut (
        .Clock        (Clock),
        .Reset        (Reset),
        .iBtnUp       (iBtnUp),
        .iBtnDown     (iBtnDown),
        .iBtnLeft     (iBtnLeft),
        .iBtnRight    (iBtnRight),
        .iBtnSelect   (iBtnSelect),
        .iHighlightEn (iHighlightEn),
        .iRedrawAck   (iRedrawAck),
        .oRGBBus      (oRGBBus),
        .oCursor      (oCursor),
        .oRedrawReq   (oRedrawReq)
    );

    typedef struct {
        string        tag;
        logic [127:0] rgb;
        logic [3:0]   cur;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] m_pal [16];
    logic [3:0] m_cur;
    int         total = 0;
    int         bad   = 0;

    // Mask bit order: {select, up, down, left, right}.
    localparam logic [4:0] B_SEL = 5'b10000, B_UP = 5'b01000, B_DN = 5'b00100;
    localparam logic [4:0] B_LT = 5'b00010, B_RT = 5'b00001;

    task automatic check(input string tag, input logic [131:0] obs, input logic [131:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic void model_reset();
        for (int k = 0; k < 16; k++) m_pal[k] = 8'(k * 17);
        m_cur = 4'd0;
    endfunction

    function automatic logic [127:0] model_rgb();
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[8*k +: 8] = m_pal[k];
        return r;
    endfunction

    function automatic void model_apply(input logic [4:0] m);
        if (m[4])      m_pal[m_cur] = m_pal[m_cur] + 8'd1;
        else if (m[3]) m_cur[3:2] = m_cur[3:2] - 2'd1;
        else if (m[2]) m_cur[3:2] = m_cur[3:2] + 2'd1;
        else if (m[1]) m_cur[1:0] = m_cur[1:0] - 2'd1;
        else if (m[0]) m_cur[1:0] = m_cur[1:0] + 2'd1;
    endfunction

    task automatic press(input logic [4:0] mask, input string tag);
        logic [127:0] old_rgb;
        logic [3:0]   old_cur;
        exp_t         e;
        old_rgb = model_rgb();
        old_cur = m_cur;
        model_apply(mask);
        e.tag = tag;
        e.rgb = model_rgb();
        e.cur = m_cur;
        sb.push_back(e);
        @(negedge Clock);
        {iBtnSelect, iBtnUp, iBtnDown, iBtnLeft, iBtnRight} = mask;
        @(posedge Clock);
        @(posedge Clock);
        @(posedge Clock); #1;
        check({tag, "_pre"}, {oRGBBus, oCursor}, {old_rgb, old_cur});
        @(posedge Clock); #1;
        e = sb.pop_front();
        check({e.tag, "_post"}, {oRGBBus, oCursor}, {e.rgb, e.cur});
        repeat (5) @(posedge Clock);
        #1;
        check({e.tag, "_hold"}, {oRGBBus, oCursor}, {e.rgb, e.cur});
        @(negedge Clock);
        {iBtnSelect, iBtnUp, iBtnDown, iBtnLeft, iBtnRight} = 5'b0;
        repeat (4) @(posedge Clock);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int   high_cnt;
        exp_t e;

        // Reset and idle.
        Reset = 1'b1;
        model_reset();
        repeat (3) @(negedge Clock);
        Reset = 1'b0;
        repeat (6) @(posedge Clock);
        #1;
        check("rst_tile0", {124'd0, oRGBBus[7:0]}, {124'd0, 8'h00});
        check("rst_tile15", {124'd0, oRGBBus[127:120]}, {124'd0, 8'hFF});
        check("rst_bus", {oRGBBus, oCursor}, {model_rgb(), 4'd0});
        check("rst_req", {131'd0, oRedrawReq}, {131'd0, 1'b0});

        // Cursor moves and colour step.
        press(B_RT, "right1");
        press(B_RT, "right2");
        press(B_DN, "down1");
        press(B_SEL, "sel6");
        check("cur_0110", {128'd0, oCursor}, {128'd0, 4'b0110});
        check("tile6_67", {124'd0, oRGBBus[55:48]}, {124'd0, 8'h67});

        // Back to tile 0, then wrap to tile 15 and wrap its colour.
        press(B_UP, "up_r0");
        press(B_LT, "left_c1");
        press(B_LT, "left_c0");
        press(B_LT, "left_wrap");
        press(B_UP, "up_wrap");
        check("cur_1111", {128'd0, oCursor}, {128'd0, 4'b1111});
        press(B_SEL, "sel15_wrap");
        check("tile15_00", {124'd0, oRGBBus[127:120]}, {124'd0, 8'h00});

        // Coincident pulses.
        press(B_DN, "down_r0");
        press(B_RT, "right_c0");
        press(B_SEL | B_RT, "sel_beats_right");
        check("tile0_01", {124'd0, oRGBBus[7:0]}, {124'd0, 8'h01});
        press(B_DN | B_LT, "down_beats_left");
        press(B_UP | B_DN | B_LT | B_RT, "up_beats_all");

        // Drain pending requests, then confirm ack in IDLE is ignored.
        @(negedge Clock);
        iRedrawAck = 1'b1;
        repeat (4) @(negedge Clock);
        iRedrawAck = 1'b0;
        repeat (3) @(posedge Clock);
        #1;
        check("drained_req", {131'd0, oRedrawReq}, {131'd0, 1'b0});
        @(negedge Clock);
        iRedrawAck = 1'b1;
        @(negedge Clock);
        iRedrawAck = 1'b0;
        repeat (3) @(posedge Clock);
        #1;
        check("idle_ack_ignored", {131'd0, oRedrawReq}, {131'd0, 1'b0});

        // Request held without ack; a second event arrives while in REQ.
        @(negedge Clock);
        iBtnRight = 1'b1;
        repeat (3) @(posedge Clock);
        #1;
        check("req_not_yet", {131'd0, oRedrawReq}, {131'd0, 1'b0});
        @(posedge Clock); #1;
        high_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            if (i == 4) iBtnRight = 1'b0;
            if (i == 6) iBtnLeft = 1'b1;
            if (i == 12) iBtnLeft = 1'b0;
            if (oRedrawReq === 1'b1) high_cnt++;
            @(posedge Clock); #1;
        end
        check("req_held20", {100'd0, 32'(high_cnt)}, {100'd0, 32'd20});
        check("cur_back0", {128'd0, oCursor}, {128'd0, 4'd0});
        @(negedge Clock);
        iRedrawAck = 1'b1;
        @(posedge Clock); #1;
        check("req_dropped", {131'd0, oRedrawReq}, {131'd0, 1'b0});
        @(negedge Clock);
        iRedrawAck = 1'b0;
        @(posedge Clock); #1;
        check("req_rearmed", {131'd0, oRedrawReq}, {131'd0, 1'b1});

        // Blink with highlight from a fresh reset, then async reset mid-REQ.
        @(negedge Clock);
        Reset = 1'b1;
        iHighlightEn = 1'b1;
        model_reset();
        @(negedge Clock);
        Reset = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            e.tag = $sformatf("blink_%0d", k);
            e.rgb = model_rgb();
            if (((k - 1) / 4) % 2 == 1) e.rgb[7:0] = m_pal[0] ^ 8'hFF;
            e.cur = 4'd0;
            sb.push_back(e);
        end
        while (sb.size() > 0) begin
            @(posedge Clock); #1;
            e = sb.pop_front();
            check(e.tag, {oRGBBus, oCursor}, {e.rgb, e.cur});
        end
        check("blink_req_high", {131'd0, oRedrawReq}, {131'd0, 1'b1});
        #2;
        Reset = 1'b1;
        #1;
        check("async_rst_req", {131'd0, oRedrawReq}, {131'd0, 1'b0});
        check("async_rst_bus", {oRGBBus, oCursor}, {model_rgb(), 4'd0});
        @(negedge Clock);
        Reset = 1'b0;
        repeat (2) @(posedge Clock);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
